// File: rtl/reg_access_ctrl.sv
// Register-file access arbiter: two 2-deep write queues and one read port share a
// single register-file command per cycle. Full queues drain first, then reads, then writes.

module reg_access_fifo #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic [AW-1:0] cmp_addr,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic [1:0]    count,
  output logic          match
);
  logic [1:0][AW-1:0] addr_q;
  logic [1:0][DW-1:0] data_q;
  logic               wptr, rptr;
  logic [1:0]         occ;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wptr] <= push_addr;
      data_q[wptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_addr = addr_q[rptr];
  assign head_data = data_q[rptr];

  // Only occupied slots take part in the read-after-write hazard compare.
  assign occ[0] = (count == 2'd2) | ((count == 2'd1) & ~rptr);
  assign occ[1] = (count == 2'd2) | ((count == 2'd1) &  rptr);
  assign match  = (occ[0] & (addr_q[0] == cmp_addr)) |
                  (occ[1] & (addr_q[1] == cmp_addr));
endmodule

module reg_access_ctrl #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr1_valid,
  input  logic [AW-1:0] wr1_addr,
  input  logic [DW-1:0] wr1_data,
  output logic          wr1_ready,
  input  logic          wr2_valid,
  input  logic [AW-1:0] wr2_addr,
  input  logic [DW-1:0] wr2_data,
  output logic          wr2_ready,
  input  logic          rd_valid,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ready,
  output logic          rd_resp_valid,
  output logic [DW-1:0] rd_resp_data,
  output logic [1:0]    rf_rw1w2,
  output logic [AW-1:0] rf_write_add_1,
  output logic [AW-1:0] rf_write_add_2,
  output logic [AW-1:0] rf_read_add,
  output logic [DW-1:0] rf_write_data_1,
  output logic [DW-1:0] rf_write_data_2,
  input  logic [DW-1:0] rf_read_data
);
  localparam int NP = 2;

  logic [NP-1:0]         wr_valid, wr_ready, push, pop, nempty, full, match;
  logic [NP-1:0][AW-1:0] wr_addr, head_addr;
  logic [NP-1:0][DW-1:0] wr_data, head_data;
  logic [NP-1:0][1:0]    count;
  logic                  hazard;
  logic [DW-1:0]         resp_hold;

  assign wr_valid = {wr2_valid, wr1_valid};
  assign wr_addr  = {wr2_addr, wr1_addr};
  assign wr_data  = {wr2_data, wr1_data};

  for (genvar i = 0; i < NP; i++) begin : g_port
    assign wr_ready[i] = rst & (count[i] != 2'd2);
    assign push[i]     = wr_valid[i] & wr_ready[i];
    assign nempty[i]   = count[i] != 2'd0;
    assign full[i]     = count[i] == 2'd2;

    reg_access_fifo #(.AW(AW), .DW(DW)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .push_addr (wr_addr[i]),
      .push_data (wr_data[i]),
      .pop       (pop[i]),
      .cmp_addr  (rd_addr),
      .head_addr (head_addr[i]),
      .head_data (head_data[i]),
      .count     (count[i]),
      .match     (match[i])
    );
  end

  assign wr1_ready = wr_ready[0];
  assign wr2_ready = wr_ready[1];
  assign hazard    = |match;

  // Writes pop every non-empty head together; the pop mask doubles as the command code.
  always_comb begin
    rd_ready = 1'b0;
    pop      = '0;
    if (rst) begin
      if (|full)                   pop      = nempty;
      else if (rd_valid && !hazard) rd_ready = 1'b1;
      else                         pop      = nempty;
    end
  end

  assign rf_rw1w2        = pop;
  assign rf_read_add     = rd_ready ? rd_addr      : '0;
  assign rf_write_add_1  = pop[0]   ? head_addr[0] : '0;
  assign rf_write_data_1 = pop[0]   ? head_data[0] : '0;
  assign rf_write_add_2  = pop[1]   ? head_addr[1] : '0;
  assign rf_write_data_2 = pop[1]   ? head_data[1] : '0;

  // Register file returns data the cycle after a read; pass it through then hold it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_resp_valid <= 1'b0;
      resp_hold     <= '0;
    end else begin
      rd_resp_valid <= rd_ready;
      if (rd_resp_valid) resp_hold <= rf_read_data;
    end
  end

  assign rd_resp_data = rd_resp_valid ? rf_read_data : resp_hold;
endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl with a behavioural register file attached.

module tb_reg_access_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       wr1_valid, wr2_valid, rd_valid;
  logic [2:0] wr1_addr, wr2_addr, rd_addr;
  logic [7:0] wr1_data, wr2_data;
  logic       wr1_ready, wr2_ready, rd_ready, rd_resp_valid;
  logic [7:0] rd_resp_data;
  logic [1:0] rf_rw1w2;
  logic [2:0] rf_write_add_1, rf_write_add_2, rf_read_add;
  logic [7:0] rf_write_data_1, rf_write_data_2;
  logic [7:0] rf_read_data = 8'h00;
  logic [7:0] regs [8] = '{default: 8'h00};

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reg_access_ctrl #(.AW(3), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .wr1_valid(wr1_valid), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ready(wr1_ready),
    .wr2_valid(wr2_valid), .wr2_addr(wr2_addr), .wr2_data(wr2_data), .wr2_ready(wr2_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
    .rf_rw1w2(rf_rw1w2),
    .rf_write_add_1(rf_write_add_1), .rf_write_add_2(rf_write_add_2), .rf_read_add(rf_read_add),
    .rf_write_data_1(rf_write_data_1), .rf_write_data_2(rf_write_data_2),
    .rf_read_data(rf_read_data)
  );

  // Register file: port 1 is applied last so it wins on an address collision.
  always @(posedge clk) begin
    if (rf_rw1w2 == 2'd0) rf_read_data <= regs[rf_read_add];
    if (rf_rw1w2[1]) regs[rf_write_add_2] <= rf_write_data_2;
    if (rf_rw1w2[0]) regs[rf_write_add_1] <= rf_write_data_1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_req(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic got;
    got = 1'b0;
    rd_valid = 1'b1;
    rd_addr  = a;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (rd_ready) got = 1'b1;
      step();
    end
    rd_valid = 1'b0;
    chk({tag, " issue"}, 32'(got), 32'd1);
    @(negedge clk);
    chk({tag, " resp_valid"}, 32'(rd_resp_valid), 32'd1);
    chk({tag, " resp_data"}, 32'(rd_resp_data), 32'(exp));
    step();
  endtask

  initial begin
    int maxlow, lowrun, p1_cnt, rd_cnt, stray;
    logic acc;
    logic [2:0] sa [4];
    logic [7:0] sd [4];
    sa[0] = 3'd1; sa[1] = 3'd2; sa[2] = 3'd4; sa[3] = 3'd6;
    sd[0] = 8'h01; sd[1] = 8'h02; sd[2] = 8'h04; sd[3] = 8'h06;

    rst = 1'b0;
    wr1_valid = 1'b1; wr1_addr = 3'd1; wr1_data = 8'h99;
    wr2_valid = 1'b1; wr2_addr = 3'd2; wr2_data = 8'h98;
    rd_valid  = 1'b1; rd_addr  = 3'd4;

    // reset state, with requests held active
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst wr1_ready", 32'(wr1_ready), 32'd0);
    chk("rst wr2_ready", 32'(wr2_ready), 32'd0);
    chk("rst rd_ready", 32'(rd_ready), 32'd0);
    chk("rst rf_rw1w2", 32'(rf_rw1w2), 32'd0);
    chk("rst rf_read_add", 32'(rf_read_add), 32'd0);
    chk("rst rf_write_add_1", 32'(rf_write_add_1), 32'd0);
    chk("rst rf_write_data_2", 32'(rf_write_data_2), 32'd0);
    chk("rst resp_valid", 32'(rd_resp_valid), 32'd0);
    chk("rst resp_data", 32'(rd_resp_data), 32'd0);
    step();
    rst = 1'b1; wr1_valid = 1'b0; wr2_valid = 1'b0; rd_valid = 1'b0;
    step();

    // single port-1 write then read back
    wr1_valid = 1'b1; wr1_addr = 3'd3; wr1_data = 8'hA5;
    @(negedge clk);
    chk("w1 ready", 32'(wr1_ready), 32'd1);
    chk("w1 idle cmd", 32'(rf_rw1w2), 32'd0);
    step();
    wr1_valid = 1'b0;
    @(negedge clk);
    chk("w1 cmd", 32'(rf_rw1w2), 32'd1);
    chk("w1 add1", 32'(rf_write_add_1), 32'd3);
    chk("w1 data1", 32'(rf_write_data_1), 32'hA5);
    chk("w1 add2 zero", 32'(rf_write_add_2), 32'd0);
    step();
    rd_req("rd3", 3'd3, 8'hA5);
    @(negedge clk);
    chk("rd3 valid drop", 32'(rd_resp_valid), 32'd0);
    chk("rd3 data hold", 32'(rd_resp_data), 32'hA5);
    step();

    // dual write, same address: port 1 prevails
    wr1_valid = 1'b1; wr1_addr = 3'd2; wr1_data = 8'h11;
    wr2_valid = 1'b1; wr2_addr = 3'd2; wr2_data = 8'h22;
    step();
    wr1_valid = 1'b0; wr2_valid = 1'b0;
    @(negedge clk);
    chk("dual cmd", 32'(rf_rw1w2), 32'd3);
    chk("dual add1", 32'(rf_write_add_1), 32'd2);
    chk("dual data1", 32'(rf_write_data_1), 32'h11);
    chk("dual add2", 32'(rf_write_add_2), 32'd2);
    chk("dual data2", 32'(rf_write_data_2), 32'h22);
    step();
    rd_req("rd2", 3'd2, 8'h11);

    // hazarded read waits for the queued port-2 write
    wr2_valid = 1'b1; wr2_addr = 3'd5; wr2_data = 8'h3C;
    step();
    wr2_valid = 1'b0; rd_valid = 1'b1; rd_addr = 3'd5;
    @(negedge clk);
    chk("haz rd_ready", 32'(rd_ready), 32'd0);
    chk("haz cmd", 32'(rf_rw1w2), 32'd2);
    chk("haz add2", 32'(rf_write_add_2), 32'd5);
    chk("haz data2", 32'(rf_write_data_2), 32'h3C);
    chk("haz add1 zero", 32'(rf_write_add_1), 32'd0);
    step();
    @(negedge clk);
    chk("haz issue", 32'(rd_ready), 32'd1);
    chk("haz read_add", 32'(rf_read_add), 32'd5);
    step();
    rd_valid = 1'b0;
    @(negedge clk);
    chk("haz resp_valid", 32'(rd_resp_valid), 32'd1);
    chk("haz resp_data", 32'(rd_resp_data), 32'h3C);
    step();

    // reads stream on addr 0 while port 1 streams writes
    maxlow = 0; p1_cnt = 0; rd_cnt = 0;
    rd_valid = 1'b1; rd_addr = 3'd0;
    for (int k = 0; k < 4; k++) begin
      wr1_valid = 1'b1; wr1_addr = sa[k]; wr1_data = sd[k];
      acc = 1'b0; lowrun = 0;
      for (int t = 0; t < 8 && !acc; t++) begin
        @(negedge clk);
        if (!rd_ready && rf_rw1w2 == 2'd1) p1_cnt++;
        if (rd_ready) rd_cnt++;
        if (wr1_ready) acc = 1'b1;
        else lowrun++;
        if (lowrun > maxlow) maxlow = lowrun;
        step();
      end
      chk("stream accept", 32'(acc), 32'd1);
    end
    wr1_valid = 1'b0;
    step();
    step();
    rd_valid = 1'b0;
    repeat (4) step();
    chk("stream max ready-low", 32'(maxlow), 32'd1);
    chk("stream P1 writes", 32'(p1_cnt), 32'd2);
    chk("stream reads", 32'(rd_cnt), 32'd4);
    rd_req("rd1", 3'd1, 8'h01);
    rd_req("rd2b", 3'd2, 8'h02);
    rd_req("rd4", 3'd4, 8'h04);
    rd_req("rd6", 3'd6, 8'h06);

    // fill both queues behind reads, then reset
    rd_valid = 1'b1; rd_addr = 3'd0;
    wr1_valid = 1'b1; wr1_addr = 3'd3; wr1_data = 8'h77;
    wr2_valid = 1'b1; wr2_addr = 3'd5; wr2_data = 8'h88;
    step();
    step();
    rst = 1'b0; wr1_valid = 1'b0; wr2_valid = 1'b0; rd_valid = 1'b0;
    @(negedge clk);
    chk("mid-rst wr1_ready", 32'(wr1_ready), 32'd0);
    chk("mid-rst wr2_ready", 32'(wr2_ready), 32'd0);
    chk("mid-rst cmd", 32'(rf_rw1w2), 32'd0);
    chk("mid-rst add1", 32'(rf_write_add_1), 32'd0);
    chk("mid-rst pending resp", 32'(rd_resp_valid), 32'd1);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("post-rst resp_valid", 32'(rd_resp_valid), 32'd0);
    chk("post-rst resp_data", 32'(rd_resp_data), 32'd0);
    chk("post-rst wr1_ready", 32'(wr1_ready), 32'd1);
    stray = 0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      if (rf_rw1w2 != 2'd0) stray++;
      step();
    end
    chk("post-rst no writes", 32'(stray), 32'd0);
    rd_req("rd3 kept", 3'd3, 8'hA5);
    rd_req("rd5 kept", 3'd5, 8'h3C);

    // read and write to the same address accepted together
    rd_valid = 1'b1; rd_addr = 3'd7;
    wr1_valid = 1'b1; wr1_addr = 3'd7; wr1_data = 8'hFF;
    @(negedge clk);
    chk("rw7 rd_ready", 32'(rd_ready), 32'd1);
    chk("rw7 wr1_ready", 32'(wr1_ready), 32'd1);
    step();
    rd_valid = 1'b0; wr1_valid = 1'b0;
    @(negedge clk);
    chk("rw7 old data", 32'(rd_resp_data), 32'h00);
    chk("rw7 resp_valid", 32'(rd_resp_valid), 32'd1);
    chk("rw7 write cmd", 32'(rf_rw1w2), 32'd1);
    chk("rw7 write add", 32'(rf_write_add_1), 32'd7);
    step();
    rd_req("rd7 new", 3'd7, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/reg_access_ctrl.md
REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

Interface
REQ-001 SHALL have parameter AW, default 3, register address width.
REQ-002 SHALL have parameter DW, default 8, register data width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports wr1_valid/wr1_addr/wr1_data  input  1/AW/DW  write request, port 1.
REQ-006 SHALL have port wr1_ready  output  1  port-1 write accepted when wr1_valid & wr1_ready at an edge.
REQ-007 SHALL have ports wr2_valid/wr2_addr/wr2_data/wr2_ready, same widths and rules, port 2.
REQ-008 SHALL have ports rd_valid/rd_addr  input  1/AW  read request.
REQ-009 SHALL have port rd_ready  output  1  read issued to the register file this cycle.
REQ-010 SHALL have ports rd_resp_valid/rd_resp_data  output  1/DW  read response, registered, no backpressure.
REQ-011 SHALL have ports rf_rw1w2  output  2  register-file command: 0 read, 1 write1, 2 write2, 3 write both.
REQ-012 SHALL have ports rf_write_add_1/rf_write_add_2/rf_read_add  output  AW each, and rf_write_data_1/rf_write_data_2  output  DW each.
REQ-013 SHALL have port rf_read_data  input  DW  register-file read result, valid the cycle after a code-0 command.

Function
REQ-014 SHALL hold a 2-entry in-order FIFO (addr+data) per write port; count 0..2.
REQ-015 SHALL drive wrN_ready = rst & (countN != 2), independent of same-cycle issue.
REQ-016 SHALL flag a hazard when rd_addr equals the address of any occupied entry in either FIFO.
REQ-017 SHALL choose one command per cycle, combinationally, in priority order:
  - P1: either FIFO full -> write(s) (rule REQ-018);
  - P2: rd_valid & no hazard -> read: rf_rw1w2=0, rf_read_add=rd_addr, rd_ready=1;
  - P3: any FIFO non-empty -> write(s);
  - P4: idle: rf_rw1w2=0, rf_read_add=0, rd_ready=0.
REQ-018 Write issue SHALL be: both non-empty -> code 3 with both heads; only FIFO1 -> code 1; only FIFO2 -> code 2; issued heads pop at the edge.
REQ-019 On code 3 with equal addresses, port-1 data SHALL prevail (register-file rule); the port-2 entry is still popped.
REQ-020 Unused rf address/data outputs SHALL be driven 0.
REQ-021 A read issued in cycle N SHALL produce rd_resp_valid=1 for exactly cycle N+1 with rd_resp_data=rf_read_data; otherwise rd_resp_valid=0, rd_resp_data holds.
REQ-022 A write accepted in the same cycle as a read issue SHALL be ordered after that read (read returns old data).
REQ-023 Simultaneous push and pop on one FIFO SHALL leave count unchanged; push to full FIFO SHALL not occur (ready low).
REQ-024 Per-port write order SHALL be preserved; cross-port order only per REQ-018/019.
REQ-025 A hazarded read SHALL wait (rd_ready=0) until all matching entries have drained, then issue.

Reset
REQ-026 While rst=0 at an edge: both FIFO counts, pointers -> 0; rd_resp_valid -> 0; rd_resp_data -> 0.
REQ-027 While rst=0: wr1_ready=wr2_ready=rd_ready=0, rf_rw1w2=0, all rf address/data outputs 0.
REQ-028 Reset mid-operation SHALL discard queued writes and any pending read response.

Verification
REQ-029 Reset, then wr1 (addr 3, 0xA5) -> code 1 next cycle; read addr 3 -> rd_resp_data=0xA5 one cycle after rd_ready.
REQ-030 wr1 (2,0x11) and wr2 (2,0x22) same cycle -> one code-3 command; read addr 2 -> 0x11.
REQ-031 wr2 (5,0x3C) queued, rd_valid addr 5 same cycle as pop -> rd_ready=0 until entry drained, response 0x3C.
REQ-032 Continuous rd_valid (addr 0) with writes streaming on port 1 -> FIFO fills, writes issue at P1, wr1_ready drops for at most the full cycles; no write lost.
REQ-033 Both FIFOs full, assert rst=0 one cycle -> counts 0, readies low during reset, no rf write issued afterwards without new requests.
REQ-034 Read addr 7 issued cycle N with wr1 (7,0xFF) accepted cycle N -> response is pre-write value; subsequent read returns 0xFF.
